// File: rtl/noc_out_port_arb.sv
// Wormhole output-port allocator: round-robin over packet heads, holds the
// grant from head to tail and muxes the owner's front flit onto the link.
module noc_out_port_arb #(
  parameter int PORT_N = 5,
  parameter int FLIT_W = 32,
  parameter int CNT_W  = 16,
  localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_N-1:0]          req_i,
  input  logic [PORT_N-1:0]          head_i,
  input  logic [PORT_N-1:0]          tail_i,
  input  logic [PORT_N*FLIT_W-1:0]   flit_i,
  output logic [PORT_N-1:0]          pop_o,
  output logic                       out_vld_o,
  output logic [FLIT_W-1:0]          out_flit_o,
  input  logic                       out_ack_i,
  output logic                       lck_o,
  output logic [PORT_N-1:0]          gnt_o,
  output logic                       err_o,
  output logic [CNT_W-1:0]           pkt_cnt_o,
  output logic                       dbg_state_o,
  output logic [IDX_W-1:0]           dbg_rr_ptr_o
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PORT_N-1:0]   gnt_q, gnt_d;
  logic                err_q, err_d;
  logic                first_q, first_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [FLIT_W-1:0]   flit_arr [PORT_N];
  logic [PORT_N-1:0]   cand;
  logic [IDX_W-1:0]    pick;
  logic                pick_vld;
  logic                own_req;
  logic                own_head;
  logic                own_tail;
  logic                out_vld;
  logic                xfer;

  for (genvar k = 0; k < PORT_N; k++) begin : g_unpack
    assign flit_arr[k] = flit_i[k*FLIT_W +: FLIT_W];
  end

  // Round-robin pick: scan rr_ptr+1, rr_ptr+2, ... modulo PORT_N.
  always_comb begin
    cand     = req_i & head_i;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= PORT_N; i++) begin
      int idx;
      idx = (int'(rr_ptr_q) + i) % PORT_N;
      if (!pick_vld && cand[idx]) begin
        pick_vld = 1'b1;
        pick     = IDX_W'(idx);
      end
    end
  end

  // Link handshake: a flit moves when out_vld_o & out_ack_i; out_vld_o never
  // depends on out_ack_i, and the offered flit is held until accepted.
  always_comb begin
    own_req    = req_i[owner_q];
    own_head   = head_i[owner_q];
    own_tail   = tail_i[owner_q];
    out_vld    = (state_q == S_LOCKED) && own_req;
    xfer       = out_vld && out_ack_i;
    out_vld_o  = out_vld;
    out_flit_o = out_vld ? flit_arr[owner_q] : '0;
    pop_o      = gnt_q & {PORT_N{xfer}};
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    err_d    = err_q;
    first_d  = first_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|(req_i & ~head_i)) begin
          err_d = 1'b1;
        end
        if (pick_vld) begin
          state_d = S_LOCKED;
          owner_d = pick;
          gnt_d   = {{(PORT_N-1){1'b0}}, 1'b1} << pick;
          first_d = 1'b1;
        end
      end
      S_LOCKED: begin
        if (xfer) begin
          first_d = 1'b0;
          // A head flit after the first one means the input lost packet framing.
          if (own_head && !first_q) begin
            err_d = 1'b1;
          end
          if (own_tail) begin
            state_d  = S_IDLE;
            gnt_d    = '0;
            rr_ptr_d = owner_q;
            cnt_d    = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= IDX_W'(PORT_N-1);
      gnt_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      err_q    <= err_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lck_o        = (state_q == S_LOCKED);
  assign gnt_o        = gnt_q;
  assign err_o        = err_q;
  assign pkt_cnt_o    = cnt_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_o));
  a_pop_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop_o));
  a_lck_gnt    : assert property (@(posedge clk) disable iff (!rst_n) (lck_o == (gnt_o != '0)));

endmodule

// File: tb/tb_noc_out_port_arb.sv
// Directed bench for noc_out_port_arb; a second CNT_W=2 instance shares the
// stimulus so the packet counter wrap can be observed.
module tb_noc_out_port_arb;
  localparam int PN = 5;
  localparam int FW = 32;
  localparam int CW = 16;
  localparam int IW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [PN-1:0]    req_i = '0;
  logic [PN-1:0]    head_i = '0;
  logic [PN-1:0]    tail_i = '0;
  logic [PN*FW-1:0] flit_i = '0;
  logic             out_ack_i = 1'b0;

  logic [PN-1:0] pop_o, gnt_o, pop_2, gnt_2;
  logic          out_vld_o, lck_o, err_o, st_o, out_vld_2, lck_2, err_2, st_2;
  logic [FW-1:0] out_flit_o, out_flit_2;
  logic [CW-1:0] pkt_cnt_o;
  logic [1:0]    pkt_cnt_2;
  logic [IW-1:0] rr_o, rr_2;

  int vectors = 0;
  int miscompares = 0;

  noc_out_port_arb #(.PORT_N(PN), .FLIT_W(FW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .flit_i(flit_i), .pop_o(pop_o), .out_vld_o(out_vld_o), .out_flit_o(out_flit_o),
    .out_ack_i(out_ack_i), .lck_o(lck_o), .gnt_o(gnt_o), .err_o(err_o),
    .pkt_cnt_o(pkt_cnt_o), .dbg_state_o(st_o), .dbg_rr_ptr_o(rr_o)
  );

  noc_out_port_arb #(.PORT_N(PN), .FLIT_W(FW), .CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .head_i(head_i), .tail_i(tail_i),
    .flit_i(flit_i), .pop_o(pop_2), .out_vld_o(out_vld_2), .out_flit_o(out_flit_2),
    .out_ack_i(out_ack_i), .lck_o(lck_2), .gnt_o(gnt_2), .err_o(err_2),
    .pkt_cnt_o(pkt_cnt_2), .dbg_state_o(st_2), .dbg_rr_ptr_o(rr_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int k, input logic r, input logic h, input logic t,
                          input logic [FW-1:0] f);
    req_i[k]  = r;
    head_i[k] = h;
    tail_i[k] = t;
    flit_i[k*FW +: FW] = f;
  endtask

  task automatic clr();
    req_i  = '0;
    head_i = '0;
    tail_i = '0;
    flit_i = '0;
  endtask

  task automatic chk_xfer(input string tag, input logic [FW-1:0] f, input logic [PN-1:0] p);
    chk({tag, "_vld"}, 64'(out_vld_o), 64'd1);
    chk({tag, "_flit"}, 64'(out_flit_o), 64'(f));
    chk({tag, "_pop"}, 64'(pop_o), 64'(p));
  endtask

  function automatic logic [FW-1:0] mk(input int k, input int p, input int f);
    return FW'(k * 32'h1000 + p * 32'h10 + f);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph[PN];
    int order[3];
    int total;
    int w;
    order = '{1, 3, 4};
    for (int k = 0; k < PN; k++) ph[k] = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    chk("rst_lck", 64'(lck_o), 64'd0);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_vld", 64'(out_vld_o), 64'd0);
    chk("rst_pop", 64'(pop_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_cnt", 64'(pkt_cnt_o), 64'd0);
    chk("rst_state", 64'(st_o), 64'd0);
    chk("rst_rr", 64'(rr_o), 64'd4);
    rst_n = 1'b1;

    // Single-flit packet on port 0
    out_ack_i = 1'b1;
    set_port(0, 1'b1, 1'b1, 1'b1, 32'hA5);
    #1;
    chk("sf_arb_vld", 64'(out_vld_o), 64'd0);
    chk("sf_arb_pop", 64'(pop_o), 64'd0);
    step();
    chk("sf_gnt", 64'(gnt_o), 64'b00001);
    chk("sf_lck", 64'(lck_o), 64'd1);
    chk_xfer("sf", 32'hA5, 5'b00001);
    step();
    clr();
    #1;
    chk("sf_done_lck", 64'(lck_o), 64'd0);
    chk("sf_done_gnt", 64'(gnt_o), 64'd0);
    chk("sf_done_cnt", 64'(pkt_cnt_o), 64'd1);
    chk("sf_done_rr", 64'(rr_o), 64'd0);
    total = 1;

    // Round-robin among ports 1,3,4, each streaming 2-flit packets
    for (int p = 0; p < 6; p++) begin
      w = order[p % 3];
      for (int j = 0; j < 3; j++)
        set_port(order[j], 1'b1, ph[order[j]] == 0, ph[order[j]] == 1, mk(order[j], p, ph[order[j]]));
      #1;
      chk("rr_arb_vld", 64'(out_vld_o), 64'd0);
      chk("rr_arb_cnt", 64'(pkt_cnt_o), 64'(total));
      if (total == 5) chk("wrap_cnt5", 64'(pkt_cnt_2), 64'd1);
      step();
      chk("rr_gnt", 64'(gnt_o), 64'(5'b1 << w));
      chk_xfer("rr_f0", mk(w, p, 0), 5'(5'b1 << w));
      step();
      ph[w] = 1;
      set_port(w, 1'b1, 1'b0, 1'b1, mk(w, p, 1));
      #1;
      chk_xfer("rr_f1", mk(w, p, 1), 5'(5'b1 << w));
      step();
      ph[w] = 0;
      total++;
    end
    clr();
    #1;
    chk("rr_cnt", 64'(pkt_cnt_o), 64'd7);
    chk("rr_lck", 64'(lck_o), 64'd0);
    chk("rr_ptr", 64'(rr_o), 64'd4);

    // Backpressure on a 4-flit packet from port 2; port 0 waits for the tail
    set_port(2, 1'b1, 1'b1, 1'b0, 32'hF0);
    #1;
    chk("bp_arb_vld", 64'(out_vld_o), 64'd0);
    step();
    chk("bp_gnt", 64'(gnt_o), 64'b00100);
    set_port(0, 1'b1, 1'b1, 1'b1, 32'hC0);
    #1;
    chk_xfer("bp_f0", 32'hF0, 5'b00100);
    step();
    set_port(2, 1'b1, 1'b0, 1'b0, 32'hF1);
    out_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_vld", 64'(out_vld_o), 64'd1);
      chk("bp_hold_flit", 64'(out_flit_o), 64'hF1);
      chk("bp_hold_pop", 64'(pop_o), 64'd0);
      chk("bp_hold_lck", 64'(lck_o), 64'd1);
      chk("bp_hold_gnt", 64'(gnt_o), 64'b00100);
      step();
    end
    out_ack_i = 1'b1;
    #1;
    chk_xfer("bp_f1", 32'hF1, 5'b00100);
    step();
    set_port(2, 1'b1, 1'b0, 1'b0, 32'hF2);
    #1;
    chk_xfer("bp_f2", 32'hF2, 5'b00100);
    step();
    set_port(2, 1'b1, 1'b0, 1'b1, 32'hF3);
    #1;
    chk_xfer("bp_f3", 32'hF3, 5'b00100);
    chk("bp_tail_gnt", 64'(gnt_o), 64'b00100);
    step();
    set_port(2, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("bp_gap_lck", 64'(lck_o), 64'd0);
    chk("bp_gap_gnt", 64'(gnt_o), 64'd0);
    chk("bp_gap_vld", 64'(out_vld_o), 64'd0);
    chk("bp_gap_cnt", 64'(pkt_cnt_o), 64'd8);
    chk("bp_gap_rr", 64'(rr_o), 64'd2);
    step();
    chk("bp_p0_gnt", 64'(gnt_o), 64'b00001);
    chk_xfer("bp_p0", 32'hC0, 5'b00001);
    step();
    clr();
    #1;
    chk("bp_p0_cnt", 64'(pkt_cnt_o), 64'd9);
    chk("bp_p0_rr", 64'(rr_o), 64'd0);

    // Mid-packet bubble on port 3
    set_port(3, 1'b1, 1'b1, 1'b0, 32'hD0);
    #1;
    step();
    chk("bub_gnt", 64'(gnt_o), 64'b01000);
    chk_xfer("bub_f0", 32'hD0, 5'b01000);
    step();
    set_port(3, 1'b0, 1'b0, 1'b0, 32'hDEAD);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bub_gap_vld", 64'(out_vld_o), 64'd0);
      chk("bub_gap_lck", 64'(lck_o), 64'd1);
      chk("bub_gap_pop", 64'(pop_o), 64'd0);
      chk("bub_gap_flit", 64'(out_flit_o), 64'd0);
      step();
    end
    set_port(3, 1'b1, 1'b0, 1'b0, 32'hD1);
    #1;
    chk_xfer("bub_f1", 32'hD1, 5'b01000);
    step();
    set_port(3, 1'b1, 1'b0, 1'b1, 32'hD2);
    #1;
    chk_xfer("bub_f2", 32'hD2, 5'b01000);
    step();
    clr();
    #1;
    chk("bub_cnt", 64'(pkt_cnt_o), 64'd10);
    chk("bub_rr", 64'(rr_o), 64'd3);
    chk("bub_lck", 64'(lck_o), 64'd0);
    chk("bub_err", 64'(err_o), 64'd0);
    chk("wrap_cnt10", 64'(pkt_cnt_2), 64'd2);

    // Body flit requesting while IDLE is an error and is not granted
    set_port(1, 1'b1, 1'b0, 1'b0, 32'hE0);
    #1;
    step();
    chk("err_idle_err", 64'(err_o), 64'd1);
    chk("err_idle_gnt", 64'(gnt_o), 64'd0);
    chk("err_idle_lck", 64'(lck_o), 64'd0);
    clr();
    step();
    chk("err_sticky", 64'(err_o), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("err_rst_err", 64'(err_o), 64'd0);
    chk("err_rst_cnt", 64'(pkt_cnt_o), 64'd0);
    step();
    rst_n = 1'b1;

    // Head flag on the second flit of a packet: flagged but still forwarded
    set_port(1, 1'b1, 1'b1, 1'b0, 32'hE1);
    #1;
    step();
    chk("err_lk_gnt", 64'(gnt_o), 64'b00010);
    chk_xfer("err_lk_f0", 32'hE1, 5'b00010);
    step();
    set_port(1, 1'b1, 1'b1, 1'b1, 32'hE2);
    #1;
    chk("err_lk_pre", 64'(err_o), 64'd0);
    chk_xfer("err_lk_f1", 32'hE2, 5'b00010);
    step();
    clr();
    #1;
    chk("err_lk_err", 64'(err_o), 64'd1);
    chk("err_lk_cnt", 64'(pkt_cnt_o), 64'd1);
    chk("err_lk_rr", 64'(rr_o), 64'd1);

    // Reset asserted during flit 2 of a port-4 packet
    set_port(4, 1'b1, 1'b1, 1'b0, 32'hB0);
    #1;
    step();
    chk("mrst_gnt", 64'(gnt_o), 64'b10000);
    chk_xfer("mrst_f0", 32'hB0, 5'b10000);
    step();
    set_port(4, 1'b1, 1'b0, 1'b0, 32'hB1);
    #1;
    chk_xfer("mrst_f1", 32'hB1, 5'b10000);
    rst_n = 1'b0;
    #1;
    chk("mrst_lck", 64'(lck_o), 64'd0);
    chk("mrst_gnt0", 64'(gnt_o), 64'd0);
    chk("mrst_vld", 64'(out_vld_o), 64'd0);
    chk("mrst_pop", 64'(pop_o), 64'd0);
    step();
    chk("mrst_hold_pop", 64'(pop_o), 64'd0);
    chk("mrst_hold_cnt", 64'(pkt_cnt_o), 64'd0);
    set_port(0, 1'b1, 1'b1, 1'b1, 32'hC1);
    set_port(4, 1'b1, 1'b1, 1'b1, 32'hB2);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_vld", 64'(out_vld_o), 64'd0);
    step();
    chk("mrst_p0_gnt", 64'(gnt_o), 64'b00001);
    chk_xfer("mrst_p0", 32'hC1, 5'b00001);
    step();
    set_port(0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    chk("mrst_cnt", 64'(pkt_cnt_o), 64'd1);
    chk("mrst_rr", 64'(rr_o), 64'd0);
    step();
    chk("mrst_p4_gnt", 64'(gnt_o), 64'b10000);
    chk_xfer("mrst_p4", 32'hB2, 5'b10000);
    step();
    clr();
    #1;
    chk("final_cnt", 64'(pkt_cnt_o), 64'd2);
    chk("final_lck", 64'(lck_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
